adc_spi_model_gen: RTL and testbench
====================================

Name: adc_spi_model_gen

Overview:
- Parametrised, self-contained behavioural model of an ADC128S-style 8-channel SPI A2D converter, for use in the controller testbenches.
- Drives packed per-channel analog readings back to the design's SPI master, and implements its own SPI slave logic.
- Beyond a fixed 4-channel model, it adds:
  - configurable channel count and resolution;
  - a per-channel sweep (droop) mode that saturates at zero;
  - deterministic zero data and a sticky flag for unmapped channels;
  - transaction counters and status outputs for scoreboarding.

Parameters:
NUM_CH, 8, number of populated channels (1..8); channel codes >= NUM_CH are unmapped
RES, 12, converter resolution in bits (8..12); data right-aligned in 16-bit frame
STEP, 16, sweep decrement applied per completed data transaction (RES-bit unsigned)

Ports:
clk  in  1  system clock; oversamples SCLK (>= 8x)
rst_n  in  1  asynchronous active-low reset
SS_n  in  1  active-low slave select from master
SCLK  in  1  serial clock from master (idle low)
MOSI  in  1  serial command data from master
MISO  out  1  serial data to master
analog_in  in  NUM_CH*RES  packed readings; channel k at [k*RES +: RES]
sweep_en  in  1  1 = apply per-channel droop after each data transaction
rdy  out  1  one-clk pulse when a 16-bit transaction completes
ch_ptr  out  3  channel latched from last command transaction
xfer_cnt  out  16  count of completed transactions, wraps at 16'hFFFF->0
bad_ch  out  1  sticky; set when an unmapped channel is addressed

Behaviour:
- Reset values: MISO=0, rdy=0, ch_ptr=0, xfer_cnt=0, bad_ch=0, FSM=CMD, all droop accumulators=0, shift registers=0, bit count=0.
- Synchronisation and edge detect:
  - SS_n, SCLK and MOSI pass through 2-flop synchronisers.
  - SCLK gets one extra flop for edge detect; rise/fall are single-clk pulses.
- SPI mode 0, 16 bits, MSB first:
  - SS_n falling (synchronised): load tx_shft with frame(ch_ptr) and clear bit count; MISO = tx_shft[15] before the first rise.
  - SCLK rise with SS_n low: rx_shft <= {rx_shft[14:0], MOSI}; bit count +1.
  - SCLK fall with SS_n low, after at least one rise: tx_shft <= {tx_shft[14:0], 1'b0}.
- Transaction completion:
  - SS_n rising with bit count == 16: transaction complete.
    - rdy pulses 1 clk.
    - cmd = rx_shft.
    - xfer_cnt increments.
  - SS_n rising with bit count != 16: aborted transaction; no rdy, no state change, counters untouched.
  - SCLK edges while SS_n high are ignored.
- Frame generation:
  - frame(c) = {(16-RES)'b0, max(analog_in[c] - droop[c], 0)} for c < NUM_CH.
  - Subtraction is performed at RES+1 bits and clamped to 0 on borrow.
  - frame(c) = 16'h0000 for c >= NUM_CH.
- FSM (2 states):
  - CMD: on complete, ch_ptr <= cmd[13:11]; if cmd[13:11] >= NUM_CH, set bad_ch; go to DATA.
  - DATA: on complete, if sweep_en and ch_ptr < NUM_CH, droop[ch_ptr] <= min(droop[ch_ptr]+STEP, 2^RES-1), saturating; go to CMD.
  - A command's data is returned in the following transaction: frame is loaded at SS_n fall using the ch_ptr current then.
- Droop:
  - Accumulators are RES bits, one per populated channel.
  - Cleared only by reset; sweep_en=0 freezes them, it does not clear them.
- Sampling: analog_in is sampled at SS_n fall only; changes mid-transaction do not affect the frame in flight.
- bad_ch is cleared only by reset.
- Reset asserted mid-transaction: everything returns to reset values immediately; the next transaction starts in CMD.
- Simultaneous SS_n rise and SCLK edge in the same clk: SS_n rise takes priority and the edge is ignored.

Test Plan:
- NUM_CH=8, RES=12; analog_in ch0=12'hABC, ch3=12'h123. Send cmd 16'h1800 (ch3), then a dummy transaction -> second MISO word = 16'h0123; rdy pulses twice; xfer_cnt=2; ch_ptr=3.
- sweep_en=1, STEP=16, ch0=12'h020. Run 3 cmd/data pairs on ch0 -> returned data 12'h020, 12'h010, 12'h000 (clamped); droop saturates without wrap.
- NUM_CH=4; cmd selecting ch5 (16'h2800) then data transaction -> MISO word 16'h0000; bad_ch=1 and stays 1 through later valid transactions.
- RES=8; ch1=8'hFF; cmd 16'h0800 then data -> MISO 16'h00FF (right-aligned, upper 8 bits zero).
- Abort: drop SS_n high after 9 SCLK rises -> no rdy, FSM still CMD, xfer_cnt unchanged; next full pair returns correct data.
- Assert rst_n low mid-data-transaction -> MISO=0, ch_ptr=0, droop cleared, xfer_cnt=0; the following pair behaves as from power-up.

Source files
------------

// File: rtl/adc_spi_model_gen.sv
// Behavioural ADC128S-style SPI A2D model: mode-0 16-bit slave with per-channel
// droop sweep, unmapped-channel flagging and transaction counters.
module adc_spi_model_gen #(
  parameter int NUM_CH = 8,
  parameter int RES    = 12,
  parameter int STEP   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  SCLK,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic [NUM_CH*RES-1:0] analog_in,
  input  logic                  sweep_en,
  output logic                  rdy,
  output logic [2:0]            ch_ptr,
  output logic [15:0]           xfer_cnt,
  output logic                  bad_ch,
  output logic                  fsm_state_o
);

  typedef enum logic {ST_CMD = 1'b0, ST_DATA = 1'b1} state_t;

  localparam logic [RES:0] STEP_W = (RES+1)'(STEP);

  // Handshake: a transaction is framed by SS_n low; it completes only when
  // SS_n rises after exactly 16 SCLK rises, otherwise it is silently dropped.
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  state_t          state_q, state_d;
  logic [15:0]     tx_q, tx_d, rx_q, rx_d;
  logic [4:0]      bit_q, bit_d;
  logic [2:0]      ch_ptr_q, ch_ptr_d;
  logic [15:0]     xfer_q, xfer_d;
  logic            bad_q, bad_d, rdy_q, rdy_d;
  logic [RES-1:0]  droop_q [NUM_CH];
  logic [RES-1:0]  droop_d [NUM_CH];

  logic            ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [15:0]     sel_frame;
  logic [RES:0]    diff, sum;

  assign ss_fall   = ss_prev_q & ~ss_sync_q;
  assign ss_rise   = ~ss_prev_q & ss_sync_q;
  assign sclk_rise = sclk_sync_q & ~sclk_prev_q & ~ss_sync_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q & ~ss_sync_q;

  // Selected channel reading minus its droop, clamped at zero on borrow.
  always_comb begin
    sel_frame = '0;
    diff      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_ptr_q == 3'(k)) begin
        diff      = {1'b0, analog_in[k*RES +: RES]} - {1'b0, droop_q[k]};
        sel_frame = diff[RES] ? 16'h0000 : 16'(diff[RES-1:0]);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    bit_d    = bit_q;
    ch_ptr_d = ch_ptr_q;
    xfer_d   = xfer_q;
    bad_d    = bad_q;
    rdy_d    = 1'b0;
    droop_d  = droop_q;
    sum      = '0;
    if (ss_fall) begin
      tx_d  = sel_frame;
      bit_d = '0;
    end else if (ss_rise) begin
      if (bit_q == 5'd16) begin
        rdy_d  = 1'b1;
        xfer_d = xfer_q + 16'd1;
        case (state_q)
          ST_CMD: begin
            ch_ptr_d = rx_q[13:11];
            if ({1'b0, rx_q[13:11]} >= 4'(NUM_CH)) bad_d = 1'b1;
            state_d = ST_DATA;
          end
          default: begin
            if (sweep_en) begin
              for (int k = 0; k < NUM_CH; k++) begin
                if (ch_ptr_q == 3'(k)) begin
                  sum        = {1'b0, droop_q[k]} + STEP_W;
                  droop_d[k] = sum[RES] ? '1 : sum[RES-1:0];
                end
              end
            end
            state_d = ST_CMD;
          end
        endcase
      end
    end else if (sclk_rise) begin
      rx_d = {rx_q[14:0], mosi_sync_q};
      if (bit_q != 5'd31) bit_d = bit_q + 5'd1;
    end else if (sclk_fall && bit_q != 5'd0) begin
      tx_d = {tx_q[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta_q   <= 1'b1;
      ss_sync_q   <= 1'b1;
      ss_prev_q   <= 1'b1;
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      state_q     <= ST_CMD;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      ch_ptr_q    <= '0;
      xfer_q      <= '0;
      bad_q       <= 1'b0;
      rdy_q       <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) droop_q[k] <= '0;
    end else begin
      ss_meta_q   <= SS_n;
      ss_sync_q   <= ss_meta_q;
      ss_prev_q   <= ss_sync_q;
      sclk_meta_q <= SCLK;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      mosi_meta_q <= MOSI;
      mosi_sync_q <= mosi_meta_q;
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      ch_ptr_q    <= ch_ptr_d;
      xfer_q      <= xfer_d;
      bad_q       <= bad_d;
      rdy_q       <= rdy_d;
      droop_q     <= droop_d;
    end
  end

  assign MISO        = tx_q[15];
  assign rdy         = rdy_q;
  assign ch_ptr      = ch_ptr_q;
  assign xfer_cnt    = xfer_q;
  assign bad_ch      = bad_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_adc_spi_model_gen.sv
// Directed bench: three model instances (8ch/12b, 4ch/12b, 8ch/8b) share one
// SPI bus and are checked against hand-computed frames and status values.
module tb_adc_spi_model_gen;

  logic clk = 1'b0;
  logic rst_n, SS_n, SCLK, MOSI;
  logic [95:0] analog_a;
  logic [47:0] analog_b;
  logic [63:0] analog_c;
  logic sweep_a, sweep_b, sweep_c;
  logic miso_a, miso_b, miso_c;
  logic rdy_a, rdy_b, rdy_c;
  logic [2:0] ptr_a, ptr_b, ptr_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic bad_a, bad_b, bad_c;
  logic st_a, st_b, st_c;

  int checks = 0;
  int failures = 0;
  int rdy_cnt_a = 0;
  int rdy_cnt_b = 0;
  logic [15:0] wa, wb, wc;

  always #5 clk = ~clk;

  adc_spi_model_gen #(.NUM_CH(8), .RES(12), .STEP(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_a),
    .analog_in(analog_a), .sweep_en(sweep_a), .rdy(rdy_a), .ch_ptr(ptr_a),
    .xfer_cnt(cnt_a), .bad_ch(bad_a), .fsm_state_o(st_a));

  adc_spi_model_gen #(.NUM_CH(4), .RES(12), .STEP(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_b),
    .analog_in(analog_b), .sweep_en(sweep_b), .rdy(rdy_b), .ch_ptr(ptr_b),
    .xfer_cnt(cnt_b), .bad_ch(bad_b), .fsm_state_o(st_b));

  adc_spi_model_gen #(.NUM_CH(8), .RES(8), .STEP(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso_c),
    .analog_in(analog_c), .sweep_en(sweep_c), .rdy(rdy_c), .ch_ptr(ptr_c),
    .xfer_cnt(cnt_c), .bad_ch(bad_c), .fsm_state_o(st_c));

  always @(negedge clk) begin
    if (rdy_a) rdy_cnt_a++;
    if (rdy_b) rdy_cnt_b++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mode-0 master: MISO sampled just before each rise, MOSI changed on the fall.
  task automatic spi_bits(input logic [15:0] cmd, input int nbits,
                          output logic [15:0] oa, output logic [15:0] ob,
                          output logic [15:0] oc);
    oa = '0; ob = '0; oc = '0;
    MOSI = cmd[15];
    SS_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      oa = {oa[14:0], miso_a};
      ob = {ob[14:0], miso_b};
      oc = {oc[14:0], miso_c};
      SCLK = 1'b1;
      wait_clks(4);
      SCLK = 1'b0;
      MOSI = (i < 15) ? cmd[14-i] : 1'b0;
      wait_clks(4);
    end
    SS_n = 1'b1;
    wait_clks(8);
    MOSI = 1'b0;
  endtask

  task automatic spi_xfer(input logic [15:0] cmd);
    spi_bits(cmd, 16, wa, wb, wc);
  endtask

  initial begin
    int ea, ec;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    sweep_a = 1'b0; sweep_b = 1'b0; sweep_c = 1'b0;
    analog_a = '0; analog_b = '0; analog_c = '0;
    analog_a[0*12 +: 12] = 12'hABC;
    analog_a[1*12 +: 12] = 12'h111;
    analog_a[3*12 +: 12] = 12'h123;
    analog_a[5*12 +: 12] = 12'h555;
    analog_b[0*12 +: 12] = 12'h321;
    analog_b[1*12 +: 12] = 12'h456;
    analog_b[3*12 +: 12] = 12'h789;
    analog_c[0*8 +: 8]   = 8'h11;
    analog_c[1*8 +: 8]   = 8'hFF;
    analog_c[3*8 +: 8]   = 8'h5A;
    analog_c[5*8 +: 8]   = 8'h33;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);

    chk("reset_miso", {31'd0, miso_a}, 32'd0);
    chk("reset_rdy", {31'd0, rdy_a}, 32'd0);
    chk("reset_ch_ptr", {29'd0, ptr_a}, 32'd0);
    chk("reset_xfer_cnt", {16'd0, cnt_a}, 32'd0);
    chk("reset_bad_ch", {31'd0, bad_b}, 32'd0);
    chk("reset_state", {31'd0, st_a}, 32'd0);

    // Command ch3; its own returned word is the frame of reset ch_ptr 0.
    spi_xfer(16'h1800);
    chk("cmd_word_ch0", {16'd0, wa}, 32'h0ABC);
    chk("cmd_ch_ptr", {29'd0, ptr_a}, 32'd3);
    chk("cmd_state_data", {31'd0, st_a}, 32'd1);
    spi_xfer(16'h0000);
    chk("data_ch3_a", {16'd0, wa}, 32'h0123);
    chk("data_ch3_b", {16'd0, wb}, 32'h0789);
    chk("data_ch3_c_res8", {16'd0, wc}, 32'h005A);
    chk("rdy_pulses_2", rdy_cnt_a, 32'd2);
    chk("xfer_cnt_2", {16'd0, cnt_a}, 32'd2);
    chk("ch_ptr_3", {29'd0, ptr_a}, 32'd3);
    chk("bad_ch_b_clear", {31'd0, bad_b}, 32'd0);

    // ch5 is populated in A and C but unmapped in the 4-channel instance.
    spi_xfer(16'h2800);
    chk("cmd2_word_ch3", {16'd0, wa}, 32'h0123);
    chk("bad_ch_b_set", {31'd0, bad_b}, 32'd1);
    chk("bad_ch_a_clear", {31'd0, bad_a}, 32'd0);
    spi_xfer(16'h0000);
    chk("data_ch5_a", {16'd0, wa}, 32'h0555);
    chk("data_ch5_b_unmapped", {16'd0, wb}, 32'h0000);
    chk("data_ch5_c", {16'd0, wc}, 32'h0033);

    spi_xfer(16'h0800);
    spi_xfer(16'h0000);
    chk("data_ch1_a", {16'd0, wa}, 32'h0111);
    chk("data_ch1_b", {16'd0, wb}, 32'h0456);
    chk("data_ch1_c_ff", {16'd0, wc}, 32'h00FF);
    chk("bad_ch_b_sticky", {31'd0, bad_b}, 32'd1);
    chk("xfer_cnt_6", {16'd0, cnt_a}, 32'd6);
    chk("rdy_b_6", rdy_cnt_b, 32'd6);

    // Abort after 9 rises: nothing observable may change.
    spi_bits(16'h1800, 9, wa, wb, wc);
    chk("abort_rdy", rdy_cnt_a, 32'd6);
    chk("abort_xfer_cnt", {16'd0, cnt_a}, 32'd6);
    chk("abort_state_cmd", {31'd0, st_a}, 32'd0);
    chk("abort_ch_ptr", {29'd0, ptr_a}, 32'd1);
    spi_xfer(16'h1800);
    spi_xfer(16'h0000);
    chk("post_abort_data", {16'd0, wa}, 32'h0123);
    chk("post_abort_xfer_cnt", {16'd0, cnt_a}, 32'd8);

    // Droop sweep on ch1: A clamps at zero, C's droop saturates at 8'hFF.
    analog_a[1*12 +: 12] = 12'h020;
    sweep_a = 1'b1;
    sweep_c = 1'b1;
    for (int n = 0; n < 17; n++) begin
      spi_xfer(16'h0800);
      spi_xfer(16'h0000);
      ea = (16 * n > 32) ? 0 : 32 - 16 * n;
      ec = (16 * n > 255) ? 0 : 255 - 16 * n;
      chk($sformatf("sweep_a_%0d", n), {16'd0, wa}, ea);
      chk($sformatf("sweep_c_%0d", n), {16'd0, wc}, ec);
      chk($sformatf("sweep_b_off_%0d", n), {16'd0, wb}, 32'h0456);
    end
    chk("sweep_xfer_cnt", {16'd0, cnt_a}, 32'd42);

    // Reset in the middle of a data transaction.
    spi_xfer(16'h0800);
    MOSI = 1'b0;
    SS_n = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b1;
      wait_clks(4);
      SCLK = 1'b0;
      wait_clks(4);
    end
    rst_n = 1'b0;
    wait_clks(1);
    chk("midreset_miso", {31'd0, miso_a}, 32'd0);
    chk("midreset_ch_ptr", {29'd0, ptr_a}, 32'd0);
    chk("midreset_xfer_cnt", {16'd0, cnt_a}, 32'd0);
    chk("midreset_state", {31'd0, st_a}, 32'd0);
    chk("midreset_bad_ch_b", {31'd0, bad_b}, 32'd0);
    SS_n = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(4);
    spi_xfer(16'h0800);
    chk("after_reset_cmd_word", {16'd0, wa}, 32'h0ABC);
    spi_xfer(16'h0000);
    chk("after_reset_droop_a", {16'd0, wa}, 32'h0020);
    chk("after_reset_droop_c", {16'd0, wc}, 32'h00FF);
    chk("after_reset_xfer_cnt", {16'd0, cnt_a}, 32'd2);
    chk("after_reset_rdy_total", rdy_cnt_a, 32'd45);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
